fractal_tile_scheduler: RTL and testbench
=========================================

Name: fractal_tile_scheduler

Overview:
- Sequences one raster frame of X_SIZE x Y_SIZE pixel coordinates onto NUM_ENGINES fractal iteration engines.
- Retires engine results strictly in raster order onto a 32-bit AXI4-Stream video output.
- Sits between the fractal engine array and the VDMA stream port, replacing the free-running single-pixel generator counters.
- Dispatch and retire both use round-robin order, so no reorder buffer is needed.

Parameters:
- X_SIZE, 640, pixels per line
- Y_SIZE, 480, lines per frame
- COORD_W, 10, width of the x/y coordinate buses; must satisfy 2^COORD_W >= max(X_SIZE, Y_SIZE)
- NUM_ENGINES, 4, number of attached engines (>=1)
- ITER_W, 8, result width per engine (<=8)

Ports:
- out_stream_aclk  in  1  single clock for the whole block
- periph_resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begin a frame
- busy  out  1  high from frame start until frame_done
- frame_done  out  1  one-cycle pulse after the last beat is accepted
- eng_start  out  NUM_ENGINES  one-hot, one-cycle dispatch pulse
- eng_x  out  COORD_W  x coordinate broadcast with eng_start
- eng_y  out  COORD_W  y coordinate broadcast with eng_start
- eng_done  in  NUM_ENGINES  per-engine one-cycle completion pulse
- eng_result  in  NUM_ENGINES*ITER_W  per-engine result; valid while that engine's eng_done is high
- out_stream_tdata  out  32  {8'h00, R, G, B}; R = G = B = result zero-extended to 8 bits
- out_stream_tkeep  out  4  constant 4'b1111 whenever tvalid
- out_stream_tvalid  out  1  output beat valid
- out_stream_tready  in  1  downstream ready
- out_stream_tuser  out  1  high on pixel (0,0) only
- out_stream_tlast  out  1  high on x = X_SIZE-1 of every line

Behaviour:
- Reset (asynchronous, immediate): all outputs 0, including tkeep. Frame FSM goes to IDLE. All slots go to FREE. Pointers and counters go to 0.
- Frame FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when start is sampled high. The issue counters (ix, iy) and retire counters (ox, oy) load 0, and busy rises on the same edge.
  - RUN -> DRAIN on the edge that issues pixel (X_SIZE-1, Y_SIZE-1).
  - DRAIN -> IDLE on the edge where the final beat handshakes (tvalid & tready with tlast and oy = Y_SIZE-1). On that same edge busy falls and frame_done pulses for one cycle.
  - start is ignored outside IDLE.
- Per-engine slot state: FREE, BUSY, DONE, plus an ITER_W result register.
- Dispatch, RUN only, at most one per cycle:
  - Condition: slot[dptr] == FREE.
  - Action: register eng_start[dptr] = 1 together with eng_x = ix and eng_y = iy; slot goes to BUSY; dptr advances modulo NUM_ENGINES; ix/iy advance in raster order (ix wraps at X_SIZE-1, iy increments).
  - eng_x and eng_y hold their values when no dispatch occurs.
- Completion: eng_done[e] with slot[e] == BUSY captures eng_result[e] and sets slot to DONE. eng_done on a FREE or DONE slot is ignored.
- Retire:
  - Condition: slot[rptr] == DONE and (!tvalid || tready).
  - Action: load tdata from the slot's result; tuser = (ox==0 && oy==0); tlast = (ox == X_SIZE-1); tvalid = 1; slot goes to FREE; rptr advances; ox/oy advance in raster order.
  - If tvalid && tready and nothing retires on that edge, tvalid drops.
  - While tvalid && !tready, tdata, tuser and tlast are held stable.
- Latency:
  - start edge k: eng_start[0] is high in cycle k+1.
  - eng_done sampled at edge n: the earliest tvalid is after edge n+1.
  - A slot freed by retire is dispatchable on the following edge, not the same edge.
- At most NUM_ENGINES pixels are outstanding. Backpressure stalls dispatch once every slot is BUSY or DONE.
- Reset mid-frame: outputs drop immediately. Stale eng_done pulses that arrive afterwards are ignored because all slots are FREE. The next start restarts the frame at (0,0).

Test Plan:
All tests use X_SIZE=4, Y_SIZE=2, NUM_ENGINES=2, ITER_W=8, tready=1 unless stated. The engine model returns result = x + 4y.
- Basic frame, model latency 3: start -> 8 beats with tdata 0x00000000, 0x00010101, ... 0x00070707. tuser on beat 0 only. tlast on beats 3 and 7. frame_done 1 cycle wide on the beat-7 handshake edge; busy low after it.
- Out-of-order completion (engine1 latency 1, engine0 latency 6): stream is still ordered 0..7; eng_start never pulses a DONE or BUSY slot.
- Backpressure, tready low for 10 cycles after beat 2:
  - tdata holds 0x00020202 with tvalid high;
  - no eng_start while both slots are non-FREE;
  - all 8 beats are delivered, none lost or duplicated.
- start pulse during RUN is ignored (one frame, 8 beats). A start one cycle after frame_done begins a new frame with tuser on its first beat.
- periph_resetn low asynchronously mid-frame after beat 3, then an eng_done injected:
  - all outputs are 0 before the next clock edge;
  - the stale done produces no beat;
  - the next start yields a full 8-beat frame from 0x00000000.
- Spurious eng_done[1] while slot 1 is FREE (IDLE and RUN): no tvalid and no state change; the frame output is unchanged.

Source files
------------

// File: rtl/fractal_tile_scheduler.sv
// fractal_tile_scheduler: raster-order dispatch of pixel coordinates onto fractal engines, retiring results in order to AXI4-Stream video.
module fractal_tile_scheduler #(
  parameter int X_SIZE      = 640,
  parameter int Y_SIZE      = 480,
  parameter int COORD_W     = 10,
  parameter int NUM_ENGINES = 4,
  parameter int ITER_W      = 8
) (
  input  logic                          out_stream_aclk,
  input  logic                          periph_resetn,
  input  logic                          start,
  output logic                          busy,
  output logic                          frame_done,
  output logic [NUM_ENGINES-1:0]        eng_start,
  output logic [COORD_W-1:0]            eng_x,
  output logic [COORD_W-1:0]            eng_y,
  input  logic [NUM_ENGINES-1:0]        eng_done,
  input  logic [NUM_ENGINES*ITER_W-1:0] eng_result,
  output logic [31:0]                   out_stream_tdata,
  output logic [3:0]                    out_stream_tkeep,
  output logic                          out_stream_tvalid,
  input  logic                          out_stream_tready,
  output logic                          out_stream_tuser,
  output logic                          out_stream_tlast
);
  localparam int PW = NUM_ENGINES > 1 ? $clog2(NUM_ENGINES) : 1;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(X_SIZE - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(Y_SIZE - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NUM_ENGINES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} frame_t;
  typedef enum logic [1:0] {FREE, BUSY, DONE} slot_t;
  frame_t state;
  slot_t slot [NUM_ENGINES];
  logic [ITER_W-1:0] res [NUM_ENGINES];
  logic [PW-1:0] dptr, rptr;
  logic [COORD_W-1:0] ix, iy, ox, oy;
  logic tend, dispatch, retire, pop;
  logic [7:0] pix;
  always_comb begin
    dispatch = state == RUN && slot[dptr] == FREE;
    pop = out_stream_tvalid && out_stream_tready;
    retire = slot[rptr] == DONE && (!out_stream_tvalid || out_stream_tready);
    pix = 8'(res[rptr]);
  end
  assign out_stream_tkeep = {4{out_stream_tvalid}};
  // Dispatch and retire walk the slots in the same round-robin order, so results leave in raster order.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state <= IDLE;
      busy <= 1'b0;
      frame_done <= 1'b0;
      eng_start <= '0;
      eng_x <= '0;
      eng_y <= '0;
      ix <= '0;
      iy <= '0;
      ox <= '0;
      oy <= '0;
      dptr <= '0;
      rptr <= '0;
      tend <= 1'b0;
      out_stream_tdata <= '0;
      out_stream_tvalid <= 1'b0;
      out_stream_tuser <= 1'b0;
      out_stream_tlast <= 1'b0;
      for (int e = 0; e < NUM_ENGINES; e++) begin
        slot[e] <= FREE;
        res[e] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      eng_start <= '0;
      if (state == IDLE && start) begin
        state <= RUN;
        busy <= 1'b1;
        ix <= '0;
        iy <= '0;
        ox <= '0;
        oy <= '0;
        dptr <= '0;
        rptr <= '0;
        tend <= 1'b0;
      end
      if (dispatch) begin
        eng_start <= NUM_ENGINES'(1) << dptr;
        eng_x <= ix;
        eng_y <= iy;
        slot[dptr] <= BUSY;
        dptr <= dptr == P_LAST ? '0 : dptr + 1'b1;
        ix <= ix == X_LAST ? '0 : ix + 1'b1;
        if (ix == X_LAST) iy <= iy + 1'b1;
        if (ix == X_LAST && iy == Y_LAST) state <= DRAIN;
      end
      for (int e = 0; e < NUM_ENGINES; e++)
        if (eng_done[e] && slot[e] == BUSY) begin
          res[e] <= eng_result[e*ITER_W +: ITER_W];
          slot[e] <= DONE;
        end
      if (retire) begin
        out_stream_tdata <= {8'h00, pix, pix, pix};
        out_stream_tuser <= ox == '0 && oy == '0;
        out_stream_tlast <= ox == X_LAST;
        out_stream_tvalid <= 1'b1;
        tend <= ox == X_LAST && oy == Y_LAST;
        slot[rptr] <= FREE;
        rptr <= rptr == P_LAST ? '0 : rptr + 1'b1;
        ox <= ox == X_LAST ? '0 : ox + 1'b1;
        if (ox == X_LAST) oy <= oy + 1'b1;
      end else if (pop) out_stream_tvalid <= 1'b0;
      // tend marks the beat holding pixel (X_SIZE-1, Y_SIZE-1); its handshake closes the frame.
      if (state == DRAIN && pop && tend) begin
        state <= IDLE;
        busy <= 1'b0;
        frame_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fractal_tile_scheduler.sv
// tb_fractal_tile_scheduler: directed bench with an engine model returning x + 4y and a stream monitor.
module tb_fractal_tile_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, tready = 1'b1;
  logic busy, frame_done, tvalid, tuser, tlast;
  logic [1:0] eng_start, eng_done;
  logic [9:0] eng_x, eng_y;
  logic [15:0] eng_result;
  logic [31:0] tdata;
  logic [3:0] tkeep;
  logic [1:0] mdone = '0, inj = '0;
  logic [7:0] mres [2];
  logic [7:0] pend [2];
  int cnt [2] = '{0, 0};
  int lat [2] = '{3, 3};
  int checks = 0, errors = 0, mviol = 0, sviol = 0;
  int dispatched = 0, loaded = 0, tv_cycles = 0, c, n, tv0;
  bit prev_tv = 0, prev_hs = 0;
  logic [31:0] bd [$];
  bit bu [$], bl [$];

  fractal_tile_scheduler #(.X_SIZE(4), .Y_SIZE(2), .COORD_W(10), .NUM_ENGINES(2), .ITER_W(8)) dut (
    .out_stream_aclk(clk), .periph_resetn(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y), .eng_done(eng_done), .eng_result(eng_result),
    .out_stream_tdata(tdata), .out_stream_tkeep(tkeep), .out_stream_tvalid(tvalid),
    .out_stream_tready(tready), .out_stream_tuser(tuser), .out_stream_tlast(tlast));

  always #5 clk = ~clk;
  assign eng_done = mdone | inj;
  assign eng_result = {mdone[1] ? mres[1] : 8'hAA, mdone[0] ? mres[0] : 8'hAA};

  // Engine model: fixed per-engine latency, flags a dispatch onto an engine still holding a pixel.
  initial forever begin
    @(posedge clk);
    #1;
    for (int e = 0; e < 2; e++) begin
      if (eng_start[e] && (cnt[e] != 0 || mdone[e])) mviol++;
      mdone[e] = 1'b0;
      if (cnt[e] != 0) begin
        cnt[e]--;
        if (cnt[e] == 0) begin
          mdone[e] = 1'b1;
          mres[e] = pend[e];
        end
      end
      if (eng_start[e]) begin
        cnt[e] = lat[e];
        pend[e] = 8'(eng_x + 4 * eng_y);
      end
    end
  end

  // Stream monitor: records accepted beats, bounds outstanding pixels to the two slots.
  always @(negedge clk) begin
    if (!rst_n) begin
      dispatched = 0;
      loaded = 0;
      tv_cycles = 0;
      prev_tv = 0;
      prev_hs = 0;
      bd.delete();
      bu.delete();
      bl.delete();
    end else begin
      if (eng_start != 2'b00) begin
        dispatched++;
        if (!$onehot(eng_start)) sviol++;
      end
      if (tvalid && (!prev_tv || prev_hs)) loaded++;
      if (dispatched - loaded > 2) sviol++;
      if (tvalid && tkeep != 4'hF) sviol++;
      if (tvalid) tv_cycles++;
      if (tvalid && tready) begin
        bd.push_back(tdata);
        bu.push_back(tuser);
        bl.push_back(tlast);
      end
      prev_tv = tvalid;
      prev_hs = tvalid && tready;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit chain);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_done && k < 300);
    chk("frame_done seen", {31'd0, frame_done}, 1);
    chk("busy low at done", {31'd0, busy}, 0);
    @(posedge clk);
    #2;
    if (chain) start = 1'b1;
    @(negedge clk);
    chk("frame_done width", {31'd0, frame_done}, 0);
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    chk({tag, " beats"}, bd.size(), 8);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = 8'(i);
      chk({tag, " tdata"}, i < bd.size() ? bd[i] : 32'hDEADBEEF, {8'h00, v, v, v});
      chk({tag, " tuser"}, i < bu.size() ? {31'd0, bu[i]} : 32'hDEADBEEF, {31'd0, i == 0});
      chk({tag, " tlast"}, i < bl.size() ? {31'd0, bl[i]} : 32'hDEADBEEF, {31'd0, i == 3 || i == 7});
    end
    chk({tag, " slot use"}, mviol + sviol, 0);
    bd.delete();
    bu.delete();
    bl.delete();
  endtask

  initial begin
    #12;
    chk("reset ctrl", {21'd0, busy, frame_done, eng_start, tvalid, tuser, tlast, tkeep}, 0);
    chk("reset tdata", tdata, 0);
    chk("reset xy", {12'd0, eng_x, eng_y}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    pulse_start;
    chk("busy rise", {31'd0, busy}, 1);
    chk("no dispatch on start edge", {30'd0, eng_start}, 0);
    @(posedge clk);
    #2;
    chk("first dispatch", {30'd0, eng_start}, 2'b01);
    chk("first xy", {12'd0, eng_x, eng_y}, 0);
    @(posedge clk);
    #2;
    chk("second dispatch", {30'd0, eng_start}, 2'b10);
    chk("second x", {22'd0, eng_x}, 1);
    c = 2;
    @(negedge clk);
    while (!tvalid && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("first beat latency", c, 6);
    wait_done(1'b0);
    check_frame("basic");
    lat[0] = 6;
    lat[1] = 1;
    pulse_start;
    wait_done(1'b0);
    check_frame("ooo");
    lat[0] = 3;
    lat[1] = 3;
    pulse_start;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(tvalid && tdata == 32'h00020202) && n < 100);
    tready = 1'b0;
    chk("bp beat2 presented", tdata, 32'h00020202);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("bp tdata hold", tdata, 32'h00020202);
      chk("bp tvalid hold", {31'd0, tvalid}, 1);
      if (i >= 3) chk("bp no dispatch", {30'd0, eng_start}, 0);
    end
    @(posedge clk);
    #2;
    tready = 1'b1;
    wait_done(1'b0);
    check_frame("bp");
    pulse_start;
    repeat (3) @(posedge clk);
    #2;
    pulse_start;
    wait_done(1'b1);
    check_frame("start in run");
    wait_done(1'b0);
    check_frame("chained");
    tv0 = tv_cycles;
    inj = 2'b10;
    @(posedge clk);
    #2;
    inj = 2'b00;
    repeat (3) @(posedge clk);
    #2;
    chk("spurious idle tvalid", tv_cycles - tv0, 0);
    chk("spurious idle busy", {31'd0, busy}, 0);
    pulse_start;
    inj = 2'b10;
    @(posedge clk);
    #2;
    inj = 2'b00;
    wait_done(1'b0);
    check_frame("spurious run");
    pulse_start;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bd.size() < 4 && n < 200);
    chk("beats before reset", {31'd0, bd.size() >= 4}, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async reset ctrl", {21'd0, busy, frame_done, eng_start, tvalid, tuser, tlast, tkeep}, 0);
    chk("async reset tdata", tdata, 0);
    chk("async reset xy", {12'd0, eng_x, eng_y}, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    inj = 2'b11;
    @(posedge clk);
    #2;
    inj = 2'b00;
    repeat (12) @(posedge clk);
    #2;
    chk("stale done tvalid", tv_cycles, 0);
    chk("stale done beats", bd.size(), 0);
    chk("stale done busy", {31'd0, busy}, 0);
    pulse_start;
    wait_done(1'b0);
    check_frame("after reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
